// File: rtl/next_sram_ctrl_pkg.sv
// Shared constants and bank-id encoding for the dual-bank SRAM controller.
package next_sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 13;
  localparam int DEF_FRAME_WORDS = 8192;

  typedef enum logic {
    BANK1 = 1'b0,
    BANK2 = 1'b1
  } bank_e;

  function automatic bank_e otherBank(input bank_e b);
    return (b == BANK1) ? BANK2 : BANK1;
  endfunction

endpackage

// File: rtl/next_sram_skid.sv
// Two-entry output FIFO with valid/ready on both sides.
module next_sram_skid
  import next_sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_in_ready  = (r_count != 2'd2);
  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = r_mem[r_rdPtr];
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;

  // Payload storage; contents are qualified by r_count so it needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_in_data;
    end
  end

  // Pointers and occupancy; reset empties the FIFO and drops buffered words
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_wrPtr <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/next_sram_ctrl.sv
// Dual-bank ping-pong SRAM controller: the producer fills one bank while
// the consumer drains the other through a 2-entry output FIFO.
module next_sram_ctrl
  import next_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic                  cs1_wr,
  output logic                  oe1_wr,
  output logic                  we1_wr,
  output logic                  cs2_wr,
  output logic                  oe2_wr,
  output logic                  we2_wr,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic                  cs1_rd,
  output logic                  oe1_rd,
  output logic                  we1_rd,
  output logic                  cs2_rd,
  output logic                  oe2_rd,
  output logic                  we2_rd,
  input  logic [DATA_WIDTH-1:0] data1_rd,
  input  logic [DATA_WIDTH-1:0] data2_rd
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

  logic [1:0]            r_full;
  bank_e                 r_wbank;
  bank_e                 r_rbank;
  bank_e                 r_infBank;
  logic [ADDR_WIDTH-1:0] r_wcnt;
  logic [ADDR_WIDTH-1:0] r_rcnt;
  logic                  r_inflight;
  logic                  r_infLast;

  logic                  w_wrFire;
  logic                  w_wrLast;
  logic                  w_issue;
  logic                  w_rdLast;
  logic [1:0]            w_fullSet;
  logic [1:0]            w_fullClr;
  logic                  w_fifoValid;
  logic                  w_fifoInReady;
  logic                  w_fifoPop;
  logic [1:0]            w_fifoCount;
  logic [1:0]            w_creditUsed;
  logic [DATA_WIDTH-1:0] w_retData;
  logic [DATA_WIDTH:0]   w_fifoHead;

  // Write side: a bank accepts words until its frame is complete
  assign wr_ready = !rst && !r_full[r_wbank];
  assign w_wrFire = wr_valid && wr_ready;
  assign w_wrLast = (r_wcnt == LAST_ADDR);

  assign cs1_wr  = w_wrFire && (r_wbank == BANK1);
  assign we1_wr  = w_wrFire && (r_wbank == BANK1);
  assign cs2_wr  = w_wrFire && (r_wbank == BANK2);
  assign we2_wr  = w_wrFire && (r_wbank == BANK2);
  assign oe1_wr  = 1'b0;
  assign oe2_wr  = 1'b0;
  assign addr_wr = rst ? '0 : r_wcnt;
  assign data_wr = wr_data;

  // Read side: credit counts FIFO entries plus the word in flight, and a pop
  // in this cycle frees a slot so the stream can sustain one word per cycle
  assign w_fifoPop    = w_fifoValid && rd_ready;
  assign w_fifoCount  = {!w_fifoInReady, w_fifoValid && w_fifoInReady};
  assign w_creditUsed = w_fifoCount + {1'b0, r_inflight} - {1'b0, w_fifoPop};
  assign w_issue      = !rst && r_full[r_rbank] && (w_creditUsed < 2'd2);
  assign w_rdLast     = (r_rcnt == LAST_ADDR);

  assign cs1_rd  = w_issue && (r_rbank == BANK1);
  assign oe1_rd  = w_issue && (r_rbank == BANK1);
  assign cs2_rd  = w_issue && (r_rbank == BANK2);
  assign oe2_rd  = w_issue && (r_rbank == BANK2);
  assign we1_rd  = 1'b0;
  assign we2_rd  = 1'b0;
  assign addr_rd = rst ? '0 : r_rcnt;

  // Frame completion marks the bank full; issuing its last word releases it
  assign w_fullSet = (w_wrFire && w_wrLast) ?
                     {r_wbank == BANK2, r_wbank == BANK1} : 2'b00;
  assign w_fullClr = (w_issue && w_rdLast) ?
                     {r_rbank == BANK2, r_rbank == BANK1} : 2'b00;

  // Bank bookkeeping: word counters, bank pointers and full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 2'b00;
      r_wbank <= BANK1;
      r_rbank <= BANK1;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
    end else begin
      if (w_wrFire) begin
        if (w_wrLast) begin
          r_wcnt  <= '0;
          r_wbank <= otherBank(r_wbank);
        end else begin
          r_wcnt <= r_wcnt + ADDR_WIDTH'(1);
        end
      end
      if (w_issue) begin
        if (w_rdLast) begin
          r_rcnt  <= '0;
          r_rbank <= otherBank(r_rbank);
        end else begin
          r_rcnt <= r_rcnt + ADDR_WIDTH'(1);
        end
      end
      r_full <= (r_full | w_fullSet) & ~w_fullClr;
    end
  end

  // Tag the single outstanding read so the returning word knows its bank and last flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_infLast  <= 1'b0;
      r_infBank  <= BANK1;
    end else begin
      r_inflight <= w_issue;
      r_infLast  <= w_issue && w_rdLast;
      r_infBank  <= r_rbank;
    end
  end

  assign w_retData = (r_infBank == BANK2) ? data2_rd : data1_rd;

  next_sram_skid #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_in_valid (r_inflight),
    .o_in_ready (w_fifoInReady),
    .i_in_data  ({r_infLast, w_retData}),
    .o_out_valid(w_fifoValid),
    .i_out_ready(rd_ready),
    .o_out_data (w_fifoHead)
  );

  assign rd_valid = w_fifoValid && !rst;
  assign rd_data  = w_fifoHead[DATA_WIDTH-1:0];
  assign rd_last  = rd_valid && w_fifoHead[DATA_WIDTH];

endmodule

// File: tb/tb_next_sram_ctrl.sv
// Self-checking bench for next_sram_ctrl with two behavioural SRAM banks
// and a frame-level reference model.
module tb_next_sram_ctrl;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] data_wr;
  logic          cs1_wr, oe1_wr, we1_wr, cs2_wr, oe2_wr, we2_wr;
  logic [AW-1:0] addr_rd;
  logic          cs1_rd, oe1_rd, we1_rd, cs2_rd, oe2_rd, we2_rd;
  logic [DW-1:0] data1_rd = '0;
  logic [DW-1:0] data2_rd = '0;

  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [DW:0] expQ[$];
  int writtenWords = 0;
  int issuedWords = 0;
  int poppedWords = 0;
  int issueCyc[$];
  int popCyc[$];
  int firstValidCyc = -1;
  int readyRiseCyc = -1;
  logic prevReady = 1'b0;
  int lastWriteCyc = 0;

  always #5 clk = ~clk;

  next_sram_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .addr_wr(addr_wr), .data_wr(data_wr),
    .cs1_wr(cs1_wr), .oe1_wr(oe1_wr), .we1_wr(we1_wr),
    .cs2_wr(cs2_wr), .oe2_wr(oe2_wr), .we2_wr(we2_wr),
    .addr_rd(addr_rd),
    .cs1_rd(cs1_rd), .oe1_rd(oe1_rd), .we1_rd(we1_rd),
    .cs2_rd(cs2_rd), .oe2_rd(oe2_rd), .we2_rd(we2_rd),
    .data1_rd(data1_rd), .data2_rd(data2_rd)
  );

  // Two synchronous SRAM banks: write on cs&we, read data one cycle after cs&oe&!we
  always @(posedge clk) begin
    if (cs1_wr && we1_wr) mem1[addr_wr] <= data_wr;
    if (cs2_wr && we2_wr) mem2[addr_wr] <= data_wr;
    if (cs1_rd && oe1_rd && !we1_rd) data1_rd <= mem1[addr_rd];
    if (cs2_rd && oe2_rd && !we2_rd) data2_rd <= mem2[addr_rd];
  end

  // Watchdog so the bench always ends even if the clocked sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    writtenWords = 0;
    issuedWords = 0;
    poppedWords = 0;
    issueCyc.delete();
    popCyc.delete();
    firstValidCyc = -1;
    readyRiseCyc = -1;
    prevReady = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model
  task automatic applyStimulus(input logic r, input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic       expReady;
    logic       wfire;
    logic       issue;
    logic       pop;
    logic [3:0] expWrCtl;
    logic [3:0] rdCtl;
    logic [3:0] expIssueVec;
    @(negedge clk);
    rst = r;
    wr_valid = wv;
    wr_data = wd;
    rd_ready = rr;
    #1;
    cycle++;
    if (r) begin
      checkOutput("reset_ctl",
                  {18'd0, cs1_wr, oe1_wr, we1_wr, cs2_wr, oe2_wr, we2_wr,
                   cs1_rd, oe1_rd, we1_rd, cs2_rd, oe2_rd, we2_rd, rd_valid, rd_last}, 32'd0);
      checkOutput("reset_addr", {6'd0, addr_wr, addr_rd}, 32'd0);
      clearModel();
    end else begin
      expReady = ((writtenWords / FW) - (issuedWords / FW)) < 2;
      checkOutput("wr_ready", wr_ready, expReady);
      wfire = wv && expReady;
      if (!wfire) expWrCtl = 4'b0000;
      else if (((writtenWords / FW) % 2) == 0) expWrCtl = 4'b1100;
      else expWrCtl = 4'b0011;
      checkOutput("wr_ctl", {cs1_wr, we1_wr, cs2_wr, we2_wr}, expWrCtl);
      checkOutput("idle_ctl", {oe1_wr, oe2_wr, we1_rd, we2_rd}, 0);
      if (wfire) begin
        checkOutput("addr_wr", addr_wr, writtenWords % FW);
        checkOutput("data_wr", data_wr, wd);
      end
      rdCtl = {cs1_rd, oe1_rd, cs2_rd, oe2_rd};
      issue = (rdCtl != 4'b0000);
      expIssueVec = (((issuedWords / FW) % 2) == 0) ? 4'b1100 : 4'b0011;
      if (issue) begin
        checkOutput("rd_ctl", rdCtl, expIssueVec);
        checkOutput("addr_rd", addr_rd, issuedWords % FW);
        checkOutput("issue_avail", issuedWords < ((writtenWords / FW) * FW), 1);
      end
      checkOutput("fifo_bound", (issuedWords - poppedWords) <= 2, 1);
      pop = rd_valid && rr;
      if (pop) begin
        checkOutput("pop_avail", poppedWords < issuedWords, 1);
        if (expQ.size() > 0)
          checkOutput("rd_word", {15'd0, rd_last, rd_data}, {15'd0, expQ[0]});
        else
          checkOutput("rd_word_extra", 1, 0);
      end
      if (rd_valid && firstValidCyc < 0) firstValidCyc = cycle;
      if (wr_ready && !prevReady) readyRiseCyc = cycle;
      prevReady = wr_ready;
      if (wfire) begin
        expQ.push_back({(writtenWords % FW) == FW - 1, wd});
        writtenWords++;
      end
      if (issue) begin
        issuedWords++;
        issueCyc.push_back(cycle);
      end
      if (pop) begin
        if (expQ.size() > 0) void'(expQ.pop_front());
        poppedWords++;
        popCyc.push_back(cycle);
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic drainUntil(input int target, input int budget);
    int n = 0;
    while (poppedWords < target && n < budget) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_count", poppedWords, target);
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;

    // Power-on reset
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("post_reset_rd_valid", rd_valid, 0);

    // Single frame
    $display("[TB] single frame");
    applyStimulus(1'b0, 1'b1, 16'h0011, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0022, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0033, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0044, 1'b1);
    drainUntil(4, 20);
    checkOutput("s1_pop_count", popCyc.size(), 4);
    if (popCyc.size() == 4) checkOutput("s1_consecutive", popCyc[3] - popCyc[0], 3);
    if (issueCyc.size() > 0) checkOutput("s1_latency", firstValidCyc - issueCyc[0], 2);

    // Ping-pong streaming
    $display("[TB] ping-pong");
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 16'(i), 1'b1);
    lastWriteCyc = cycle;
    drainUntil(8, 30);
    if (issueCyc.size() > 0) checkOutput("s2_overlap", issueCyc[0] < lastWriteCyc, 1);

    // Both banks full
    $display("[TB] both full");
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("s3_wr_ready_low", wr_ready, 0);
    checkOutput("s3_rd_valid", rd_valid, 1);
    checkOutput("s3_head", rd_data, 16'h0001);
    checkOutput("s3_issued", issuedWords, 2);
    readyRiseCyc = -1;
    drainUntil(8, 40);
    if (issueCyc.size() >= 4) checkOutput("s3_release", readyRiseCyc - issueCyc[3], 1);

    // Back-pressure with toggling rd_ready
    $display("[TB] back-pressure");
    doReset();
    applyStimulus(1'b0, 1'b1, 16'h00A1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h00A2, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h00A3, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h00A4, 1'b1);
    for (int k = 0; k < 40 && poppedWords < 4; k++)
      applyStimulus(1'b0, 1'b0, '0, logic'(k % 2));
    checkOutput("s4_popped", poppedWords, 4);

    // Reset mid-frame
    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(1'b0, 1'b1, 16'hAAAA, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'hBBBB, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("s5_wr_ready", wr_ready, 1);
    checkOutput("s5_rd_valid", rd_valid, 0);
    applyStimulus(1'b0, 1'b1, 16'h0101, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0202, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0303, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0404, 1'b1);
    drainUntil(4, 20);

    // Randomized traffic against the frame model
    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, logic'($urandom_range(0, 3) != 0), 16'($urandom), logic'($urandom_range(0, 1)));
    drainUntil((writtenWords / FW) * FW, 100);
    checkOutput("rand_leftover", expQ.size(), writtenWords % FW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
